// File: rtl/window_sum_decoder.sv
// Inverts a WINDOW-sample moving sum back into the original sample stream.
// One registered output stage behind a valid/ready handshake; all math is mod 2^WIDTH.
module window_sum_decoder #(
    parameter int WIDTH  = 8,
    parameter int WINDOW = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum,
    input  logic             restart,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d_out,
    output logic             out_first
);

    localparam int HIST_W = WINDOW * WIDTH;

    // d[k] = s[k] - s[k-1] + d[k-WINDOW]; wrap-around is the intended behaviour.
    function automatic logic [WIDTH-1:0] decode_wrap(
        input logic [WIDTH-1:0] s_cur,
        input logic [WIDTH-1:0] s_prev,
        input logic [WIDTH-1:0] d_old
    );
        return s_cur - s_prev + d_old;
    endfunction

    logic [WIDTH-1:0]  prev_sum_q, prev_sum_d;
    logic [HIST_W-1:0] hist_q, hist_d;
    logic              fresh_q, fresh_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  d_out_q, d_out_d;
    logic              out_first_q, out_first_d;

    logic              accept;
    logic [WIDTH-1:0]  dec;
    logic [WIDTH-1:0]  hist_oldest;

    assign in_ready    = !out_valid_q || out_ready;
    assign accept      = in_valid && in_ready;
    // Newest sample sits in the low slot; the oldest, d[k-WINDOW], in the top slot.
    assign hist_oldest = hist_q[HIST_W-1 -: WIDTH];
    assign dec         = decode_wrap(sum, prev_sum_q, hist_oldest);

    always_comb begin
        prev_sum_d  = prev_sum_q;
        hist_d      = hist_q;
        fresh_d     = fresh_q;
        out_valid_d = out_valid_q;
        d_out_d     = d_out_q;
        out_first_d = out_first_q;

        if (accept) begin
            prev_sum_d  = sum;
            fresh_d     = 1'b0;
            out_valid_d = 1'b1;
            if (restart) begin
                d_out_d     = sum;
                out_first_d = 1'b1;
                hist_d      = {{((WINDOW-1)*WIDTH){1'b0}}, sum};
            end else begin
                d_out_d     = dec;
                out_first_d = fresh_q;
                hist_d      = {hist_q[HIST_W-WIDTH-1:0], dec};
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_sum_q  <= '0;
            hist_q      <= '0;
            fresh_q     <= 1'b1;
            out_valid_q <= 1'b0;
            d_out_q     <= '0;
            out_first_q <= 1'b0;
        end else begin
            prev_sum_q  <= prev_sum_d;
            hist_q      <= hist_d;
            fresh_q     <= fresh_d;
            out_valid_q <= out_valid_d;
            d_out_q     <= d_out_d;
            out_first_q <= out_first_d;
        end
    end

    assign out_valid = out_valid_q;
    assign d_out     = d_out_q;
    assign out_first = out_first_q;

endmodule

// File: doc/window_sum_decoder.md
# window_sum_decoder

Recovers the original sample stream from a stream of WINDOW-sample moving sums, inverting the sliding-window summer used elsewhere in the design. It sits downstream of a link that carries window sums and reconstructs each sample d[k] from sum s[k] using d[k] = s[k] − s[k−1] + d[k−WINDOW], all modulo 2^WIDTH. Stream history before reset or restart is zero. Input and output use valid/ready handshakes, with one registered output stage.

## Interface
- WIDTH, 8, bit width of sums and samples; all arithmetic is modulo 2^WIDTH.
- WINDOW, 3, number of samples in each input sum; legal range 2..16.

- clk  input  1  Single clock; all state updates on its rising edge.
- reset  input  1  Asynchronous, active-low reset: asserted when 0, released when 1.
- in_valid  input  1  The value on sum is valid.
- in_ready  output  1  The block accepts sum this cycle; combinational, equal to !out_valid || out_ready.
- sum  input  WIDTH  Moving sum s[k] = d[k] + d[k−1] + … + d[k−WINDOW+1].
- restart  input  1  Sampled only on an accepted beat. This beat is s[0] of a new stream.
- out_valid  output  1  d_out holds a recovered sample.
- out_ready  input  1  The consumer takes d_out this cycle.
- d_out  output  WIDTH  Recovered sample d[k].
- out_first  output  1  Qualified by out_valid. d_out is the first sample after a reset or restart.

## Operation
- Internal state:
  - prev_sum (WIDTH): the last accepted sum.
  - hist: a shift register of WINDOW recovered samples; hist[0] is the newest and hist[WINDOW−1] is d[k−WINDOW].
  - fresh: set by reset, cleared by the first accepted beat.
- Accept condition: in_valid && in_ready.
- Normal accepted beat (restart=0):
  - d = sum − prev_sum + hist[WINDOW−1], truncated to WIDTH.
  - hist shifts by one, with hist[0] = d; prev_sum = sum.
  - d_out = d, out_valid = 1, out_first = fresh, fresh = 0.
- Restart beat (restart=1): the block computes as if prev_sum and hist were all zero.
  - d = sum; hist = {sum, 0, …, 0}; prev_sum = sum.
  - out_first = 1.
- Output hold: when out_valid=1 and out_ready=0, d_out, out_first and all state hold. in_ready=0 and nothing is accepted.
- Simultaneous drain and accept: when out_valid=1, out_ready=1 and in_valid=1, the old word drains and the new word loads in the same edge, with no bubble.
- Drain without accept: when out_ready=1 and no beat is accepted, out_valid goes to 0 next edge.
- Reset values (asynchronous, immediate while reset=0):
  - out_valid=0, d_out=0, out_first=0.
  - prev_sum=0, hist all 0, fresh=1.
  - in_ready reads 1 after reset, since out_valid=0.
- Reset mid-stream: pending output is discarded and history is cleared. The next accepted beat decodes as stream start, with out_first=1.
- Wrap-around: sums that overflowed WIDTH upstream decode exactly, because all ops are mod 2^WIDTH. No overflow flag.
- in_valid is ignored while in_ready=0. restart without in_valid has no effect.

## Timing
- Latency: a sum accepted at edge n appears on d_out with out_valid=1 after edge n.
- Throughput: one sample per cycle when out_ready is held high.
- in_ready depends combinationally on out_ready only. There is no path from in_valid to in_ready.
- The arithmetic is single-cycle: one subtract and one add feed the d_out register.
- Decode is correct only if the upstream stream begins at reset or restart with zero history.

## Test plan
- Basic decode (WIDTH=8, WINDOW=3): sums 5, 12, 21, 18 with out_ready=1 → d_out 5, 7, 9, 2 on consecutive cycles. out_first=1 only on the 5.
- Wrap-around: sums 200, 44, 94, 160 → d_out 200, 100, 50, 10.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 → d_out stable and in_ready=0. On release, the held word drains, and a simultaneously presented sum loads the next edge with no bubble.
- Restart mid-stream: after the sums from the basic test, send 30 with restart=1, then 33 → d_out 30 (out_first=1), then 3.
- Reset mid-stream: assert reset for 1 cycle while out_valid=1 → out_valid=0 immediately. After release, sum 8 → d_out 8 with out_first=1.
- WINDOW=2 regression: samples 1, 2, 3, 4 → sums 1, 3, 5, 7 → d_out 1, 2, 3, 4.
